// File: rtl/video_timing_gen.sv
// video_timing_gen: raster timing generator with H/V counters, blanking,
// sync generation, blanked RGB, latched sync centring, a programmable line
// interrupt and a frame-start strobe.
// Optional feature macro: VTG_INTERLACE_EN (interlaced fields, FIELD output,
// extra blanked line and half-line vsync offset in the odd field).
// Timing advances only on MCLK edges where PCLK_EN is high; all registered
// outputs are derived from the pre-increment counters, so they lag HPOS/VPOS
// by one enabled pixel.
module video_timing_gen #(
    parameter int H_ACTIVE = 336,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 48,
    parameter int H_BP     = 54,
    parameter int V_ACTIVE = 240,
    parameter int V_FP     = 8,
    parameter int V_SYNC   = 11,
    parameter int V_BP     = 3,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CW       = 8
) (
    input  logic          MCLK,
    input  logic          RESET,
    input  logic          PCLK_EN,
    input  logic [3:0]    H_ADJ,
    input  logic [3:0]    V_ADJ,
    input  logic [8:0]    IRQ_LINE,
    input  logic          IRQ_ACK,
    input  logic [CW-1:0] iRGB,
    output logic [8:0]    HPOS,
    output logic [8:0]    VPOS,
    output logic [CW-1:0] oRGB,
    output logic          HBLK,
    output logic          VBLK,
    output logic          HSYN,
    output logic          VSYN,
    output logic          VIRQ,
    output logic          FSTART,
    output logic          FIELD
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_BASE = H_ACTIVE + H_FP;
    localparam int VS_BASE = V_ACTIVE + V_FP;

    logic [8:0]    r_hcnt;
    logic [8:0]    r_vcnt;
    logic [3:0]    r_ha;
    logic [3:0]    r_va;
    logic          r_hblk;
    logic          r_vblk;
    logic          r_hsyn;
    logic          r_vsyn;
    logic [CW-1:0] r_rgb;
    logic          r_virq;
    logic          r_fstart;

    logic          w_h_last;
    logic          w_v_last;
    logic          w_frame_wrap;
    logic [11:0]   w_hcnt_x;
    logic [11:0]   w_vcnt_x;
    logic [11:0]   w_hs_start;
    logic [11:0]   w_hs_end;
    logic [11:0]   w_vs_start;
    logic [11:0]   w_vs_end;
    logic          w_hs_act;
    logic          w_vs_act;
    logic          w_irq_hit;

    assign w_h_last     = (r_hcnt == 9'(H_TOTAL - 1));
    assign w_frame_wrap = w_h_last && w_v_last;
    assign w_hcnt_x     = {3'b000, r_hcnt};
    assign w_vcnt_x     = {3'b000, r_vcnt};

    // Sync windows use the adjust values latched at the last frame wrap, so a
    // mid-frame change of H_ADJ/V_ADJ only takes effect in the next frame.
    assign w_hs_start = 12'(HS_BASE) + {{8{r_ha[3]}}, r_ha};
    assign w_hs_end   = w_hs_start + 12'(H_SYNC);
    assign w_vs_start = 12'(VS_BASE) + {{8{r_va[3]}}, r_va};
    assign w_vs_end   = w_vs_start + 12'(V_SYNC);
    assign w_hs_act   = (w_hcnt_x >= w_hs_start) && (w_hcnt_x < w_hs_end);

    // Lines at or beyond V_TOTAL never raise the interrupt, even if the odd
    // interlaced field briefly counts one line past V_TOTAL-1.
    assign w_irq_hit = (r_hcnt == 9'd0) && (r_vcnt == IRQ_LINE) &&
                       (IRQ_LINE < 9'(V_TOTAL));

`ifdef VTG_INTERLACE_EN
    localparam int H_HALF = H_TOTAL / 2;

    logic r_field;
    logic w_vs_even;
    logic w_vs_odd;

    // The odd field carries one extra (blanked) line at the end of the frame.
    assign w_v_last  = r_field ? (r_vcnt == 9'(V_TOTAL)) : (r_vcnt == 9'(V_TOTAL - 1));
    assign w_vs_even = (w_vcnt_x >= w_vs_start) && (w_vcnt_x < w_vs_end);
    // Odd field: the whole vsync window is shifted by half a line.
    assign w_vs_odd  = ((w_vcnt_x > w_vs_start) ||
                        ((w_vcnt_x == w_vs_start) && (r_hcnt >= 9'(H_HALF)))) &&
                       ((w_vcnt_x < w_vs_end) ||
                        ((w_vcnt_x == w_vs_end) && (r_hcnt < 9'(H_HALF))));
    assign w_vs_act  = r_field ? w_vs_odd : w_vs_even;
    assign FIELD     = r_field;

    // Field flag toggles at every frame wrap.
    always_ff @(posedge MCLK) begin
        if (RESET) begin
            r_field <= 1'b0;
        end else if (PCLK_EN && w_frame_wrap) begin
            r_field <= ~r_field;
        end
    end
`else
    assign w_v_last = (r_vcnt == 9'(V_TOTAL - 1));
    assign w_vs_act = (w_vcnt_x >= w_vs_start) && (w_vcnt_x < w_vs_end);
    assign FIELD    = 1'b0;
`endif

    // Horizontal and vertical pixel counters.
    always_ff @(posedge MCLK) begin
        if (RESET) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
        end else if (PCLK_EN) begin
            if (w_h_last) begin
                r_hcnt <= '0;
                r_vcnt <= w_v_last ? 9'd0 : r_vcnt + 9'd1;
            end else begin
                r_hcnt <= r_hcnt + 9'd1;
            end
        end
    end

    // Sync-centring adjust is captured only when the frame wraps to (0,0).
    always_ff @(posedge MCLK) begin
        if (RESET) begin
            r_ha <= '0;
            r_va <= '0;
        end else if (PCLK_EN && w_frame_wrap) begin
            r_ha <= H_ADJ;
            r_va <= V_ADJ;
        end
    end

    // Blanking, syncs and blanked pixel, registered from the current counters.
    always_ff @(posedge MCLK) begin
        if (RESET) begin
            r_hblk <= 1'b1;
            r_vblk <= 1'b1;
            r_hsyn <= ~HS_POL;
            r_vsyn <= ~VS_POL;
            r_rgb  <= '0;
        end else if (PCLK_EN) begin
            r_hblk <= (r_hcnt >= 9'(H_ACTIVE));
            r_vblk <= (r_vcnt >= 9'(V_ACTIVE));
            r_hsyn <= w_hs_act ? HS_POL : ~HS_POL;
            r_vsyn <= w_vs_act ? VS_POL : ~VS_POL;
            r_rgb  <= ((r_hcnt >= 9'(H_ACTIVE)) || (r_vcnt >= 9'(V_ACTIVE))) ? '0 : iRGB;
        end
    end

    // Line interrupt: set on the first pixel of IRQ_LINE, a set beats an ack.
    always_ff @(posedge MCLK) begin
        if (RESET) begin
            r_virq <= 1'b0;
        end else if (PCLK_EN && w_irq_hit) begin
            r_virq <= 1'b1;
        end else if (IRQ_ACK) begin
            r_virq <= 1'b0;
        end
    end

    // Frame-start strobe: one MCLK wide, on the edge that wraps to (0,0).
    always_ff @(posedge MCLK) begin
        if (RESET) begin
            r_fstart <= 1'b0;
        end else begin
            r_fstart <= PCLK_EN && w_frame_wrap;
        end
    end

    assign HPOS   = r_hcnt;
    assign VPOS   = r_vcnt;
    assign oRGB   = r_rgb;
    assign HBLK   = r_hblk;
    assign VBLK   = r_vblk;
    assign HSYN   = r_hsyn;
    assign VSYN   = r_vsyn;
    assign VIRQ   = r_virq;
    assign FSTART = r_fstart;

endmodule
